// File: rtl/alu_cmd_driver.sv
// Command-side initiator for a registered ALU. Accepts one operation per
// valid/ready handshake, drives registered operands/op to the ALU, waits out
// the ALU register latency, captures Z/overflow and returns them on a
// valid/ready response channel. Supports result chaining and keeps a
// saturating overflow-event counter.
module alu_cmd_driver #(
  // Register stages inside the driven ALU; legal range 1..15.
  parameter int unsigned ALU_LAT      = 1,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // Command channel
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]   cmd_a_i,
  input  logic [DATA_WIDTH-1:0]   cmd_b_i,
  input  logic [ALU_OP_WIDTH-1:0] cmd_op_i,
  input  logic                    cmd_chain_i,
  // ALU side
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  output logic [ALU_OP_WIDTH-1:0] alu_ctrl_o,
  input  logic [DATA_WIDTH-1:0]   alu_z_i,
  input  logic                    alu_ovf_i,
  // Response channel
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_z_o,
  output logic                    rsp_ovf_o,
  // Debug
  output logic [7:0]              ovf_count_o,
  input  logic                    ovf_clr_i,
  output logic                    busy_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] LatInit = 4'(ALU_LAT);

  logic [1:0]              state_q, state_d;
  logic [3:0]              lat_cnt_q, lat_cnt_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [ALU_OP_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0]   rsp_z_q, rsp_z_d;
  logic                    rsp_ovf_q, rsp_ovf_d;
  logic [DATA_WIDTH-1:0]   last_z_q, last_z_d;
  logic [7:0]              ovf_count_q, ovf_count_d;
  logic                    cmd_ready_q, rsp_valid_q, busy_q;
  logic                    accept;
  logic                    capture;

  // Handshake qualifies on the registered ready so nothing is taken in the
  // cycle right after reset release, while cmd_ready_o is still low.
  assign accept = cmd_valid_i & cmd_ready_q & (state_q == StIdle);

  // FSM next state, latency countdown and operand loading.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_ctrl_d = alu_ctrl_q;
    capture    = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          alu_a_d    = cmd_chain_i ? last_z_q : cmd_a_i;
          alu_b_d    = cmd_b_i;
          alu_ctrl_d = cmd_op_i;
          lat_cnt_d  = LatInit;
          state_d    = StExec;
        end
      end
      StExec: begin
        // Count reaches zero at the edge where ALU Z reflects our operands;
        // the capture happens on the edge after that.
        if (lat_cnt_q != 4'd0) begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Result capture into the response holding registers and the chain source.
  always_comb begin
    rsp_z_d   = rsp_z_q;
    rsp_ovf_d = rsp_ovf_q;
    last_z_d  = last_z_q;
    if (capture) begin
      rsp_z_d   = alu_z_i;
      rsp_ovf_d = alu_ovf_i;
      last_z_d  = alu_z_i;
    end
  end

  // Saturating overflow counter; a clear beats a coincident increment.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr_i) begin
      ovf_count_d = 8'd0;
    end else if (capture && alu_ovf_i && (ovf_count_q != 8'hFF)) begin
      ovf_count_d = ovf_count_q + 8'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lat_cnt_q   <= 4'd0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_z_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      last_z_q    <= '0;
      ovf_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_z_q     <= rsp_z_d;
      rsp_ovf_q   <= rsp_ovf_d;
      last_z_q    <= last_z_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // Registered status outputs, decoded from the next state so they line up
  // with state_q; all read 0 while in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cmd_ready_q <= (state_d == StIdle);
      rsp_valid_q <= (state_d == StResp);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_ctrl_o  = alu_ctrl_q;
  assign rsp_z_o     = rsp_z_q;
  assign rsp_ovf_o   = rsp_ovf_q;
  assign ovf_count_o = ovf_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a transaction-level model checked every cycle
// against the ALU_LAT=1 instance, directed literal checks on both the
// ALU_LAT=1 and an ALU_LAT=3 instance, each driving a behavioural ALU.
module tb_alu_cmd_driver;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  // ALU_LAT=1 instance
  logic       cmd_valid = 1'b0, cmd_chain = 1'b0, rsp_ready = 1'b0, ovf_clr = 1'b0;
  logic [7:0] cmd_a = '0, cmd_b = '0;
  logic [3:0] cmd_op = '0;
  logic       cmd_ready, rsp_valid, rsp_ovf, busy, alu_ovf;
  logic [7:0] alu_a, alu_b, alu_z, rsp_z, ovf_count;
  logic [3:0] alu_ctrl;
  // ALU_LAT=3 instance
  logic       d3_valid = 1'b0, d3_chain = 1'b0, d3_rsp_ready = 1'b0, d3_clr = 1'b0;
  logic [7:0] d3_a = '0, d3_b = '0;
  logic [3:0] d3_op = '0;
  logic       d3_ready, d3_rsp_valid, d3_rsp_ovf, d3_busy, d3_alu_ovf;
  logic [7:0] d3_alu_a, d3_alu_b, d3_alu_z, d3_rsp_z, d3_ovf_count;
  logic [3:0] d3_alu_ctrl;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_driver #(.ALU_LAT(1), .DATA_WIDTH(8), .ALU_OP_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .cmd_op_i(cmd_op), .cmd_chain_i(cmd_chain),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_ctrl_o(alu_ctrl), .alu_z_i(alu_z),
    .alu_ovf_i(alu_ovf),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_z_o(rsp_z), .rsp_ovf_o(rsp_ovf),
    .ovf_count_o(ovf_count), .ovf_clr_i(ovf_clr), .busy_o(busy)
  );

  alu_cmd_driver #(.ALU_LAT(3), .DATA_WIDTH(8), .ALU_OP_WIDTH(4)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(d3_valid), .cmd_ready_o(d3_ready), .cmd_a_i(d3_a), .cmd_b_i(d3_b),
    .cmd_op_i(d3_op), .cmd_chain_i(d3_chain),
    .alu_a_o(d3_alu_a), .alu_b_o(d3_alu_b), .alu_ctrl_o(d3_alu_ctrl), .alu_z_i(d3_alu_z),
    .alu_ovf_i(d3_alu_ovf),
    .rsp_valid_o(d3_rsp_valid), .rsp_ready_i(d3_rsp_ready), .rsp_z_o(d3_rsp_z),
    .rsp_ovf_o(d3_rsp_ovf),
    .ovf_count_o(d3_ovf_count), .ovf_clr_i(d3_clr), .busy_o(d3_busy)
  );

  // Reference ALU behaviour: {overflow, Z}; overflow is signed for add/sub.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [7:0] z;
    logic       v;
    v = 1'b0;
    case (op)
      OpAdd: begin z = a + b; v = (a[7] == b[7]) && (z[7] != a[7]); end
      OpSub: begin z = a - b; v = (a[7] != b[7]) && (z[7] != a[7]); end
      OpAnd: z = a & b;
      OpOr:  z = a | b;
      OpXor: z = a ^ b;
      default: z = 8'd0;
    endcase
    return {v, z};
  endfunction

  // Behavioural ALUs with 1 and 3 register stages, sharing the reset.
  logic [8:0] p1_q;
  logic [8:0] p3_q [3];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= '0;
      p3_q[0] <= '0; p3_q[1] <= '0; p3_q[2] <= '0;
    end else begin
      p1_q <= alu_ref(alu_a, alu_b, alu_ctrl);
      p3_q[0] <= alu_ref(d3_alu_a, d3_alu_b, d3_alu_ctrl);
      p3_q[1] <= p3_q[0];
      p3_q[2] <= p3_q[1];
    end
  end
  assign alu_z      = p1_q[7:0];
  assign alu_ovf    = p1_q[8];
  assign d3_alu_z   = p3_q[2][7:0];
  assign d3_alu_ovf = p3_q[2][8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Transaction model for the ALU_LAT=1 instance: one command in flight,
  // response appears LAT+1 edges after acceptance with the computed result.
  localparam int ModelLat = 1;
  logic       m_ready = 0, m_busy = 0, m_rsp = 0, m_ovf = 0, m_pend_ovf = 0;
  logic [7:0] m_a = 0, m_b = 0, m_z = 0, m_last = 0, m_pend_z = 0;
  logic [3:0] m_op = 0;
  int         m_age = 0, m_cnt = 0;

  initial forever begin
    logic cap;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ready = 0; m_busy = 0; m_rsp = 0; m_ovf = 0; m_a = 0; m_b = 0; m_op = 0;
      m_z = 0; m_last = 0; m_cnt = 0; m_age = 0;
    end else begin
      cap = 0;
      if (m_ready && cmd_valid) begin
        m_a = cmd_chain ? m_last : cmd_a;
        m_b = cmd_b;
        m_op = cmd_op;
        {m_pend_ovf, m_pend_z} = alu_ref(m_a, m_b, m_op);
        m_busy = 1; m_age = 0;
      end else if (m_busy && !m_rsp) begin
        m_age++;
        if (m_age == ModelLat + 1) begin
          cap = 1; m_rsp = 1; m_z = m_pend_z; m_ovf = m_pend_ovf; m_last = m_pend_z;
        end
      end else if (m_rsp && rsp_ready) begin
        m_rsp = 0; m_busy = 0;
      end
      m_ready = !m_busy;
      if (ovf_clr) m_cnt = 0;
      else if (cap && m_pend_ovf && m_cnt < 255) m_cnt++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
    chk("rsp_z", 32'(rsp_z), 32'(m_z));
    chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("alu_a", 32'(alu_a), 32'(m_a));
    chk("alu_b", 32'(alu_b), 32'(m_b));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_op));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the LAT=1 instance; returns the accept cycle.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      input logic chain, output int acc);
    for (int n = 0; n < 50 && !cmd_ready; n++) tick();
    if (!cmd_ready) chk("send_timeout", 32'(cmd_ready), 32'd1);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int n = 0; n < 50 && !rsp_valid; n++) tick();
    if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got running expected finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1;
    logic [7:0] sa, sb;
    logic [3:0] sop;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
    chk("rst_d3_ready", 32'(d3_ready), 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("rel_ready_high", 32'(cmd_ready), 32'd1);

    // Single add, rsp_ready held high.
    rsp_ready = 1'b1;
    send(8'd5, 8'd7, OpAdd, 1'b0, e0);
    chk("add_alu_a", 32'(alu_a), 32'd5);
    tick();
    chk("add_no_rsp_e1", 32'(rsp_valid), 32'd0);
    tick();
    chk("add_rsp_e2", 32'(rsp_valid), 32'd1);
    chk("add_z", 32'(rsp_z), 32'd12);
    chk("add_ovf", 32'(rsp_ovf), 32'd0);
    tick();
    chk("add_consumed", 32'(rsp_valid), 32'd0);
    chk("add_ready_back", 32'(cmd_ready), 32'd1);

    // Chained add with backpressure; cmd_a is ignored.
    rsp_ready = 1'b0;
    send(8'd99, 8'd3, OpAdd, 1'b1, e1);
    chk("accept_to_accept", 32'(e1 - e0), 32'd4);
    chk("chain_alu_a", 32'(alu_a), 32'd12);
    wait_rsp();
    chk("chain_z", 32'(rsp_z), 32'd15);
    cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = OpOr; cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_z_stable", 32'(rsp_z), 32'd15);
      chk("bp_ready_low", 32'(cmd_ready), 32'd0);
      chk("bp_alu_a_held", 32'(alu_a), 32'd12);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", 32'(rsp_valid), 32'd0);

    // Overflow counting and saturation.
    send(8'd127, 8'd1, OpAdd, 1'b0, e0);
    wait_rsp();
    chk("ovf_flag", 32'(rsp_ovf), 32'd1);
    chk("ovf_z", 32'(rsp_z), 32'h80);
    chk("ovf_count1", 32'(ovf_count), 32'd1);
    for (int i = 0; i < 300; i++) begin
      send(8'd127, 8'd1, OpAdd, 1'b0, e0);
      wait_rsp();
    end
    tick();
    chk("ovf_sat", 32'(ovf_count), 32'd255);

    // Clear on the same edge as an overflow capture.
    send(8'd127, 8'd1, OpAdd, 1'b0, e0);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_capture", 32'(rsp_valid), 32'd1);
    chk("clr_ovf_flag", 32'(rsp_ovf), 32'd1);
    chk("clr_wins", 32'(ovf_count), 32'd0);

    // A few other ops.
    send(8'h80, 8'h01, OpSub, 1'b0, e0);
    wait_rsp();
    chk("sub_z", 32'(rsp_z), 32'h7F);
    chk("sub_ovf", 32'(rsp_ovf), 32'd1);
    send(8'hF0, 8'h3C, OpXor, 1'b0, e0);
    wait_rsp();
    chk("xor_z", 32'(rsp_z), 32'hCC);
    chk("xor_count", 32'(ovf_count), 32'd1);

    // Reset during EXEC discards the command and the chain value.
    send(8'd10, 8'd20, OpAdd, 1'b0, e0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(ovf_count), 32'd0);
    tick();
    rst_n = 1'b1;
    send(8'd55, 8'd4, OpAdd, 1'b1, e0);
    chk("mid_chain_a", 32'(alu_a), 32'd0);
    wait_rsp();
    chk("mid_chain_z", 32'(rsp_z), 32'd4);
    tick();

    // ALU_LAT=3 instance: capture at E4, operands held E0..E4.
    chk("d3_ready", 32'(d3_ready), 32'd1);
    d3_a = 8'd100; d3_b = 8'd27; d3_op = OpAdd; d3_valid = 1'b1; d3_rsp_ready = 1'b1;
    tick();
    d3_valid = 1'b0;
    d3_a = 8'd1; d3_b = 8'd2; d3_op = OpXor;
    sa = d3_alu_a; sb = d3_alu_b; sop = d3_alu_ctrl;
    chk("d3_alu_a", 32'(sa), 32'd100);
    chk("d3_alu_b", 32'(sb), 32'd27);
    chk("d3_alu_ctrl", 32'(sop), 32'(OpAdd));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("d3_rsp_valid", 32'(d3_rsp_valid), (k == 4) ? 32'd1 : 32'd0);
      chk("d3_hold_a", 32'(d3_alu_a), 32'd100);
      chk("d3_hold_b", 32'(d3_alu_b), 32'd27);
      chk("d3_hold_ctrl", 32'(d3_alu_ctrl), 32'(OpAdd));
    end
    chk("d3_z", 32'(d3_rsp_z), 32'd127);
    chk("d3_ovf", 32'(d3_rsp_ovf), 32'd0);
    tick();
    chk("d3_consumed", 32'(d3_rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command-side initiator for the registered ALU (`sync_alu`). It accepts one operation per valid/ready handshake and drives the ALU operand and control ports with registered values. After the ALU's fixed register latency it captures `Z`/`overflow` and returns them on a valid/ready response channel. It also supports result chaining (previous result reused as operand A) and keeps a saturating overflow-event counter for lab-level debug.

## Interface
- `ALU_LAT`, default 1: number of register stages inside the driven ALU (edges from operands applied to `Z` updated); legal range 1–15.
- `clk` in 1: single clock for all logic; the same clock drives the ALU.
- `rst_n` in 1: asynchronous, active-low reset; shared with the ALU.
- `cmd_valid` in 1: a command is present.
- `cmd_ready` out 1: the driver accepts a command this cycle.
- `cmd_a` in `DATA_WIDTH`: operand A; ignored when `cmd_chain`=1.
- `cmd_b` in `DATA_WIDTH`: operand B.
- `cmd_op` in `ALU_OP_WIDTH`: ALU operation code, passed through unmodified.
- `cmd_chain` in 1: use the last captured result as operand A.
- `alu_a`, `alu_b` out `DATA_WIDTH`: registered operands, connect to ALU `A`/`B`.
- `alu_ctrl` out `ALU_OP_WIDTH`: registered op, connect to ALU `aluctrl`.
- `alu_z` in `DATA_WIDTH`: ALU `Z`.
- `alu_ovf` in 1: ALU `overflow`.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_z` out `DATA_WIDTH`: captured result.
- `rsp_ovf` out 1: captured overflow.
- `ovf_count` out 8: saturating count of captured overflows.
- `ovf_clr` in 1: synchronous clear of `ovf_count`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`, at that edge:
    - load `alu_a` with (`cmd_chain` ? `last_z` : `cmd_a`);
    - load `alu_b` with `cmd_b` and `alu_ctrl` with `cmd_op`;
    - load `lat_cnt` with `ALU_LAT`;
    - go to EXEC.
- **EXEC**
  - `cmd_ready`=0.
  - At each edge: if `lat_cnt`≠0, decrement it.
  - If `lat_cnt`=0, capture `alu_z`→`rsp_z` and `last_z`, capture `alu_ovf`→`rsp_ovf`, and go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_z` and `rsp_ovf` stay stable until the handshake.
  - On `rsp_ready`=1, at that edge go to IDLE.
  - `cmd_ready` stays 0 throughout RESP, so there is no overlap and at most one command is in flight.
- `alu_a`, `alu_b` and `alu_ctrl` hold their values from accept until the next accept; they never change during EXEC.
- `last_z` is an internal register: reset 0, updated only on capture. A chained command issued before any capture uses 0.
- **`ovf_count`**
  - +1 at a capture edge with `alu_ovf`=1; saturates at 255.
  - `ovf_clr` sets it to 0 at the next edge. If clear and increment fall on the same edge, the clear wins and the result is 0.
- The driver does no arithmetic and no width conversion. `cmd_op` encodings are as defined in `define.v`.
- **Reset**
  - Async assertion at any point (including mid-EXEC or RESP) forces IDLE and discards the command in flight.
  - All outputs reset to 0 except `cmd_ready`, which is 1 in IDLE once reset deasserts.
  - `last_z`, `lat_cnt` and `ovf_count` reset to 0.

## Timing
- Let the accept edge be E0 (`cmd_valid` & `cmd_ready`).
- The ALU sees the new operands from E0 and registers `Z` at edge E(`ALU_LAT`).
- The driver captures at edge E(`ALU_LAT`+1). `rsp_valid` is high from that edge.
- The earliest response handshake is edge E(`ALU_LAT`+2); `cmd_ready` rises after it.
- With `ALU_LAT`=1 and `rsp_ready` held high, an operation takes 4 cycles accept-to-accept.
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `cmd_valid` asserted while not in IDLE is ignored; the command is not consumed.
- `busy` equals (state≠IDLE) and is registered.

## Test plan
- **Reset values:** assert `rst_n`=0 → all outputs 0. Release → `cmd_ready`=1 on the next cycle, `ovf_count`=0.
- **Single add:** `cmd_a`=5, `cmd_b`=7, add op, `ALU_LAT`=1, `rsp_ready`=1 → `rsp_valid` is high 2 edges after accept with `rsp_z`=12 and `rsp_ovf`=0. It is consumed 1 edge later, and the next command is accepted 4 cycles after the first.
- **Chain and backpressure:**
  - Add 5+7, then a chained add with `cmd_b`=3 (`cmd_a`=99 is ignored) → `alu_a`=12, `rsp_z`=15.
  - Hold `rsp_ready`=0 for 5 cycles → `rsp_z`=15 stays stable and `cmd_ready` stays 0.
- **Overflow counting:**
  - Signed add of max positive + 1 → `rsp_ovf`=1, `ovf_count`=1.
  - Repeat 300 times → `ovf_count`=255.
  - Pulse `ovf_clr` on the same edge as an overflow capture → `ovf_count`=0.
- **Reset mid-operation:** accept a command, then assert `rst_n`=0 during EXEC → IDLE, no `rsp_valid`, `last_z`=0. A following chained add with `cmd_b`=4 returns 4.
- **Latency parameter:** with `ALU_LAT`=3 and an ALU model carrying 3 stages → capture at E4 and the correct `rsp_z`. Assert that `alu_a`, `alu_b` and `alu_ctrl` are unchanged during E0–E4.
